// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer: session state encoding
// and the default counter width with its saturation value.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_RUN,
      ST_CHK_REQ,
      ST_CHK_CMP,
      ST_DONE
   } state_e;

   localparam int unsigned CNT_WIDTH_DEF = 16;
   localparam logic [CNT_WIDTH_DEF-1:0] MAX_CNT = '1;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with a zero flag; it stops at zero rather than
// wrapping, so a stray decrement can never restart a phase.
module cycle_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/boot_sequencer.sv
// Bring-up session controller: holds the CPU in reset, clears and loads RAM,
// runs the CPU for a fixed budget, then checks RAM against expected values.
module boot_sequencer
   import boot_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned CLEAR_DEPTH = 256,
   parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  run_cycles,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   input  logic                  chk_valid,
   output logic                  chk_ready,
   input  logic [ADDR_WIDTH-1:0] chk_addr,
   input  logic [DATA_WIDTH-1:0] chk_data,
   input  logic                  chk_last,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr
);

   localparam int unsigned CTR_WIDTH = (CNT_WIDTH > ADDR_WIDTH) ? CNT_WIDTH : ADDR_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CLEAR_LAST = CTR_WIDTH'(CLEAR_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] ERR_MAX    = '1;

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  budget_q, budget_d;
   logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
   logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
   logic                  exp_last_q, exp_last_d;
   logic [CNT_WIDTH-1:0]  err_q, err_d;
   logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;

   logic                  ctr_load;
   logic [CTR_WIDTH-1:0]  ctr_load_val;
   logic                  ctr_dec;
   logic [CTR_WIDTH-1:0]  ctr_count;
   logic                  ctr_zero;
   logic                  idle_like;
   logic                  ld_fire;
   logic                  chk_fire;
   logic [ADDR_WIDTH-1:0] clear_addr;

   assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign ld_fire   = (state_q == ST_LOAD) && ld_valid;
   assign chk_fire  = (state_q == ST_CHK_REQ) && chk_valid;
   // The counter runs down, so the ascending clear address is its complement.
   assign clear_addr = ADDR_WIDTH'(CLEAR_LAST - ctr_count);

   cycle_counter #(
      .WIDTH(CTR_WIDTH)
   ) u_cycle_counter (
      .clk       (clk),
      .rst       (rst),
      .load_i    (ctr_load),
      .load_val_i(ctr_load_val),
      .dec_i     (ctr_dec),
      .count_o   (ctr_count),
      .zero_o    (ctr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every comb output gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_CLEAR;
         ST_CLEAR:         if (ctr_zero) state_d = ST_LOAD;
         ST_LOAD: begin
            if (ld_fire && ld_last) begin
               state_d = (budget_q == '0) ? ST_CHK_REQ : ST_RUN;
            end
         end
         ST_RUN:           if (ctr_zero) state_d = ST_CHK_REQ;
         ST_CHK_REQ:       if (chk_fire) state_d = ST_CHK_CMP;
         ST_CHK_CMP:       state_d = exp_last_q ? ST_DONE : ST_CHK_REQ;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_rst   = (state_q != ST_RUN);
      busy      = !idle_like;
      done      = (state_q == ST_DONE);
      pass      = (state_q == ST_DONE) && (err_q == '0);
      ld_ready  = (state_q == ST_LOAD);
      chk_ready = (state_q == ST_CHK_REQ);
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clear_addr;
         end
         ST_LOAD: begin
            if (ld_valid) begin
               mem_we    = 1'b1;
               mem_addr  = ld_addr;
               mem_wdata = ld_data;
            end
         end
         ST_CHK_REQ: if (chk_valid) mem_addr = chk_addr;
         default: ;
      endcase
   end

   // Counter sequencing: clear length on start, run budget on the last load beat.
   always_comb begin
      ctr_load     = 1'b0;
      ctr_load_val = '0;
      ctr_dec      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               ctr_load     = 1'b1;
               ctr_load_val = CLEAR_LAST;
            end
         end
         ST_CLEAR, ST_RUN: ctr_dec = !ctr_zero;
         ST_LOAD: begin
            if (ld_fire && ld_last && (budget_q != '0)) begin
               ctr_load     = 1'b1;
               ctr_load_val = CTR_WIDTH'(budget_q) - CTR_WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      budget_d    = budget_q;
      exp_data_d  = exp_data_q;
      exp_addr_d  = exp_addr_q;
      exp_last_d  = exp_last_q;
      err_d       = err_q;
      first_err_d = first_err_q;
      if (idle_like && start) begin
         budget_d    = run_cycles;
         err_d       = '0;
         first_err_d = '0;
      end
      if (chk_fire) begin
         exp_data_d = chk_data;
         exp_addr_d = chk_addr;
         exp_last_d = chk_last;
      end
      if ((state_q == ST_CHK_CMP) && (mem_rdata != exp_data_q)) begin
         if (err_q != ERR_MAX) err_d = err_q + CNT_WIDTH'(1);
         if (err_q == '0) first_err_d = exp_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         budget_q    <= '0;
         exp_data_q  <= '0;
         exp_addr_q  <= '0;
         exp_last_q  <= 1'b0;
         err_q       <= '0;
         first_err_q <= '0;
      end else begin
         budget_q    <= budget_d;
         exp_data_q  <= exp_data_d;
         exp_addr_q  <= exp_addr_d;
         exp_last_q  <= exp_last_d;
         err_q       <= err_d;
         first_err_q <= first_err_d;
      end
   end

   assign err_count      = err_q;
   assign first_err_addr = first_err_q;

endmodule
